// File: rtl/instr_decode_ctrl.sv
// Fetch/decode/execute/writeback sequencer for the 16-bit RISC core.
// It fetches over a req/ack port, decodes register-file addresses and controls, and owns the program counter.
module instr_decode_ctrl #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            clr,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_data,
  input  logic [15:0]     a_data,
  output logic [3:0]      Aaddr,
  output logic [3:0]      Baddr,
  output logic [3:0]      Caddr,
  output logic            load,
  output logic [2:0]      alu_op,
  output logic            imm_sel,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0]      op;
  logic            is_alu, is_ldi, is_jmp, is_bz, is_halt, is_undef;
  logic [PC_W-1:0] bz_off;

  assign op       = ir_q[15:12];
  assign is_alu   = (op >= 4'h1) && (op <= 4'h7);
  assign is_ldi   = (op == 4'h8);
  assign is_jmp   = (op == 4'h9);
  assign is_bz    = (op == 4'hA);
  assign is_halt  = (op == 4'hF);
  assign is_undef = (op >= 4'hB) && (op <= 4'hE);
  // The branch offset lives in the rd field and is signed.
  assign bz_off   = {{(PC_W-4){ir_q[11]}}, ir_q[11:8]};

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
        if (is_jmp) begin
          pc_d = ir_q[PC_W-1:0];
        end else if (is_bz && (a_data == 16'h0000)) begin
          pc_d = pc_q + bz_off;
        end
        if (is_halt) begin
          pc_d    = pc_q;
          state_d = S_HALT;
        end else if (is_alu || is_ldi) begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Decoded fields follow ir, so they stay put from DECODE until the next fetch lands.
  assign Aaddr    = ir_q[7:4];
  assign Baddr    = ir_q[3:0];
  assign Caddr    = ir_q[11:8];
  assign alu_op   = is_alu ? (op[2:0] - 3'd1) : 3'd0;
  assign imm_sel  = is_ldi;
  assign imm      = {8'h00, ir_q[7:0]};

  assign mem_req  = (state_q == S_FETCH);
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign load     = (state_q == S_WB);
  assign halted   = (state_q == S_HALT);
  assign illegal  = (state_q == S_DECODE) && is_undef;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Scoreboard bench for instr_decode_ctrl: expected fetch/writeback/illegal events are queued
// by the stimulus and popped by a negedge monitor as the DUT presents them.
module tb_instr_decode_ctrl;

  localparam int PC_W = 8;
  localparam int K_FETCH = 0;
  localparam int K_WB    = 1;
  localparam int K_ILL   = 2;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack = 1'b0;
  logic [15:0]     mem_data = 16'h0000;
  logic [15:0]     a_data = 16'h0000;
  logic [3:0]      Aaddr, Baddr, Caddr;
  logic            load;
  logic [2:0]      alu_op;
  logic            imm_sel;
  logic [15:0]     imm;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            illegal;

  instr_decode_ctrl #(.PC_W(PC_W)) dut (
    .clk(clk), .clr(clr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .a_data(a_data),
    .Aaddr(Aaddr), .Baddr(Baddr), .Caddr(Caddr), .load(load),
    .alu_op(alu_op), .imm_sel(imm_sel), .imm(imm), .pc(pc),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int addr;
    int len;
    int c;
    int a;
    int b;
    int alu;
    int sel;
    int imm;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_f(input int addr, input int len);
    ev_t e = '{K_FETCH, addr, len, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(e);
  endtask

  task automatic push_wb(input int c, input int a, input int b, input int alu, input int sel, input int im);
    ev_t e = '{K_WB, 0, 0, c, a, b, alu, sel, im};
    exp_q.push_back(e);
  endtask

  task automatic push_ill();
    ev_t e = '{K_ILL, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int  cyc = 0;
  int  ack_cyc = -100;
  int  req_len = 0;
  int  cur_len = 0;
  int  held_addr = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (clr) begin
      req_prev = 1'b0;
      req_len  = 0;
    end else begin
      if (mem_req) begin
        if (!req_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_fetch", 32'(mem_addr), -1);
          end else begin
            e = exp_q.pop_front();
            chk("fetch_kind", K_FETCH, e.kind);
            chk("fetch_addr", 32'(mem_addr), e.addr);
            $display("fetch addr=0x%02h (expected 0x%02h)", mem_addr, e.addr);
            cur_len = e.len;
          end
          held_addr = 32'(mem_addr);
          req_len   = 1;
        end else begin
          req_len++;
          chk("addr_stable", 32'(mem_addr), held_addr);
        end
        if (mem_ack) ack_cyc = cyc;
      end else if (req_prev && cur_len > 0) begin
        chk("req_length", req_len, cur_len);
      end
      if (load) begin
        chk("load_vs_req", 32'(mem_req), 0);
        chk("load_latency", cyc - ack_cyc, 3);
        if (exp_q.size() == 0) begin
          chk("unexpected_load", 32'(Caddr), -1);
        end else begin
          e = exp_q.pop_front();
          chk("wb_kind", K_WB, e.kind);
          chk("wb_Caddr", 32'(Caddr), e.c);
          chk("wb_Aaddr", 32'(Aaddr), e.a);
          chk("wb_Baddr", 32'(Baddr), e.b);
          chk("wb_alu_op", 32'(alu_op), e.alu);
          chk("wb_imm_sel", 32'(imm_sel), e.sel);
          chk("wb_imm", 32'(imm), e.imm);
          $display("writeback C=%0d A=%0d B=%0d alu=%0d sel=%0d imm=0x%04h", Caddr, Aaddr, Baddr, alu_op, imm_sel, imm);
        end
      end
      if (illegal) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_illegal", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ill_kind", K_ILL, e.kind);
          $display("illegal pulse at pc=0x%02h", pc);
        end
      end
      req_prev = mem_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic serve(input logic [15:0] data, input int wt, input logic [15:0] ad);
    int n = 0;
    while (!mem_req && n < 50) begin
      tick();
      n++;
    end
    if (!mem_req) begin
      chk("fetch_timeout", 0, 1);
      return;
    end
    repeat (wt) tick();
    mem_ack  = 1'b1;
    mem_data = data;
    a_data   = ad;
    tick();
    mem_ack  = 1'b0;
  endtask

  task automatic do_reset();
    clr     = 1'b1;
    mem_ack = 1'b0;
    tick();
    tick();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_req"}, 32'(mem_req), 1);
    chk({tag, "_load"}, 32'(load), 0);
    chk({tag, "_illegal"}, 32'(illegal), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_addrs"}, 32'({Aaddr, Baddr, Caddr}), 0);
    chk({tag, "_alu_sel"}, 32'({alu_op, imm_sel}), 0);
    chk({tag, "_imm"}, 32'(imm), 0);
  endtask

  initial begin
    int req_seen;

    // Program 1: mixed instructions, branches, jumps, pc wrap, halt.
    do_reset();
    chk_reset_outputs("reset");
    push_f(8'h00, 1); push_wb(3, 5, 10, 0, 1, 16'h005A);
    push_f(8'h01, 4); push_wb(1, 2, 4, 0, 0, 16'h0024);
    push_f(8'h02, 2); push_wb(6, 7, 8, 1, 0, 16'h0078);
    push_f(8'h03, 1); push_wb(15, 14, 13, 6, 0, 16'h00ED);
    push_f(8'h04, 1); push_ill();
    push_f(8'h05, 3);
    push_f(8'h06, 1);
    push_f(8'h07, 1);
    push_f(8'h05, 1);
    push_f(8'h07, 1);
    push_f(8'h08, 1);
    push_f(8'hFF, 1);
    push_f(8'h00, 1);
    push_f(8'hFE, 1); push_wb(9, 10, 11, 4, 0, 16'h00AB);
    push_f(8'hFF, 1);
    clr = 1'b0;
    serve(16'h835A, 0, 16'h0000);   // LDI r3,0x5A
    serve(16'h1124, 3, 16'h0000);   // ADD r1,r2,r4
    serve(16'h2678, 1, 16'h0000);   // SUB r6,r7,r8
    serve(16'h7FED, 0, 16'h0000);   // SHR r15,r14,r13
    serve(16'hB000, 0, 16'h0000);   // undefined
    serve(16'h0000, 2, 16'h0000);   // NOP
    serve(16'h9007, 0, 16'h0000);   // JMP 7
    serve(16'hAE50, 0, 16'h0000);   // BZ r5,-2 taken -> 5
    serve(16'h9007, 0, 16'h0000);   // JMP 7
    serve(16'hAE50, 0, 16'h0001);   // BZ r5,-2 not taken -> 8
    serve(16'h90FF, 0, 16'h0000);   // JMP 0xFF
    serve(16'h0000, 0, 16'h0000);   // NOP at 0xFF wraps to 0
    serve(16'hAE50, 0, 16'h0000);   // BZ at 0 wraps back to 0xFE
    serve(16'h59AB, 0, 16'h0000);   // XOR r9,r10,r11
    serve(16'hF000, 0, 16'h0000);   // HALT at 0xFF
    req_seen = 0;
    repeat (25) begin
      tick();
      if (mem_req) req_seen++;
    end
    chk("halt_req_cycles", req_seen, 0);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_pc", 32'(pc), 8'hFF);
    chk("prog1_drained", exp_q.size(), 0);

    // Reset mid-fetch, with a simultaneous ack that must be ignored.
    do_reset();
    push_f(8'h00, 1); push_wb(3, 5, 10, 0, 1, 16'h005A);
    push_f(8'h01, 0);
    clr = 1'b0;
    serve(16'h835A, 0, 16'h0000);
    while (!mem_req) tick();
    tick();
    tick();
    clr      = 1'b1;
    mem_ack  = 1'b1;
    mem_data = 16'h1124;
    tick();
    mem_ack  = 1'b0;
    chk_reset_outputs("rst_fetch");
    exp_q.delete();

    // Reset during WB.
    tick();
    push_f(8'h00, 1); push_wb(1, 2, 4, 0, 0, 16'h0024);
    clr = 1'b0;
    serve(16'h1124, 0, 16'h0000);
    tick();
    tick();
    chk("wb_load_before_rst", 32'(load), 1);
    #4;
    clr = 1'b1;
    tick();
    chk_reset_outputs("rst_wb");
    exp_q.delete();

    // Restart from pc 0 after reset.
    tick();
    push_f(8'h00, 1);
    push_f(8'h01, 1);
    clr = 1'b0;
    serve(16'h0000, 0, 16'h0000);
    serve(16'hF000, 0, 16'h0000);
    repeat (5) tick();
    chk("restart_halted", 32'(halted), 1);
    chk("restart_pc", 32'(pc), 1);
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_decode_ctrl.md
# instr_decode_ctrl

Multi-cycle fetch/decode/control sequencer for the 16-bit RISC core, sitting directly upstream of the 16x16 register file. It fetches 16-bit instructions from instruction memory over a req/ack handshake and decodes them into register-file read addresses (Aaddr, Baddr), a write address (Caddr), the write-enable pulse (load), ALU opcode and immediate. It also maintains the program counter, including jumps and branch-on-zero.

## Interface
- PC_W, 8, program-counter width in bits; the instruction address space is 2^PC_W words.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  synchronous, active-high reset.
- mem_req  out  1  instruction fetch request.
- mem_addr  out  PC_W  fetch address; equals pc while mem_req=1.
- mem_ack  in  1  fetch complete; mem_data valid in the same cycle.
- mem_data  in  16  instruction word.
- a_data  in  16  register-file port A read value, used for BZ.
- Aaddr  out  4  register-file read address A.
- Baddr  out  4  register-file read address B.
- Caddr  out  4  register-file write address.
- load  out  1  register-file write enable; a one-cycle pulse.
- alu_op  out  3  ALU function select.
- imm_sel  out  1  1 selects imm for the write data instead of the ALU result.
- imm  out  16  zero-extended ir[7:0].
- pc  out  PC_W  current program counter.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded.

## Operation
- Instruction fields: op=ir[15:12], rd=ir[11:8], rs=ir[7:4], rt=ir[3:0].
- Opcodes:
  - 0000 NOP.
  - 0001–0111: ADD, SUB, AND, OR, XOR, SHL, SHR. Write rd; alu_op=op[2:0]-1, i.e. ADD=0 … SHR=6.
  - 1000 LDI: rd <= {8'h00, ir[7:0]}; imm_sel=1.
  - 1001 JMP: pc <= ir[PC_W-1:0].
  - 1010 BZ: if a_data==0, pc <= pc + sext(ir[11:8]); otherwise pc+1.
  - 1111 HALT.
  - 1011–1110: undefined. Treated as NOP, and illegal pulses in DECODE.
- States:
  - FETCH: mem_req=1. On mem_ack, latch ir <= mem_data and go to DECODE. Otherwise hold in FETCH, with mem_req staying high.
  - DECODE: drive Aaddr=rs, Baddr=rt, Caddr=rd from ir. Go to EXEC.
  - EXEC: resolve the next pc:
    - pc+1 by default;
    - the JMP target;
    - BZ evaluated on a_data in this cycle (the register file is combinational read).
    - Write ops and LDI go to WB; all others go to FETCH.
    - HALT goes to HALT with pc unchanged.
  - WB: load=1 for exactly this cycle. Go to FETCH.
  - HALT: terminal. Only clr exits it.
- Aaddr, Baddr, Caddr, alu_op, imm_sel and imm are decoded from ir and held stable from DECODE until the next mem_ack.
- PC arithmetic is modulo 2^PC_W. Increment from all-ones wraps to 0; a BZ offset wraps both ways.

## Timing
- Reset (clr=1 at a rising edge, in any state) forces:
  - state=FETCH, pc=0, ir=16'h0000;
  - load=0, illegal=0, halted=0;
  - Aaddr=Baddr=Caddr=0, alu_op=0, imm_sel=0, imm=0.
- Reset takes priority over everything, including a simultaneous mem_ack. A pending fetch is abandoned and mem_req re-asserts at pc=0 in the first cycle after reset.
- mem_req is asserted in the first FETCH cycle.
- From an ack at edge N:
  - write instructions: DECODE at N+1, EXEC at N+2, WB (load=1) at N+3, FETCH at N+4. That is 4 cycles plus memory wait.
  - non-write instructions: 3 cycles plus memory wait.
- mem_ack outside FETCH is ignored.
- mem_addr is stable for the whole request.
- The pc update takes effect at the EXEC→next edge. The new pc is visible on mem_addr in the following FETCH.
- load never asserts in the same cycle as mem_req.

## Test plan
- Reset then run with ack after 0 wait cycles, program LDI r3,0x5A:
  - mem_addr=0;
  - Caddr=3, imm=0x005A, imm_sel=1;
  - load high exactly 1 cycle, 3 cycles after the ack;
  - next fetch at address 1.
- ADD r1,r2,r4 (0x1124) with a 3-cycle ack wait:
  - mem_req held 4 cycles, addr stable;
  - Aaddr=2, Baddr=4, Caddr=1, alu_op=0, one load pulse.
- BZ r5,-2 (0xAE50) at pc=7:
  - a_data=0 → next fetch at 5;
  - a_data=1 → next fetch at 8;
  - load never asserts.
- JMP 0xFF then NOP at 0xFF (PC_W=8):
  - fetch from 0xFF, then the next fetch wraps to 0x00.
- Opcode 0xB000:
  - illegal pulses 1 cycle, no load, pc+1.
- HALT 0xF000:
  - halted=1, mem_req stays 0 for 20+ cycles, pc frozen.
- clr asserted mid-fetch and in WB:
  - all outputs return to their reset values on the next edge;
  - load is 0;
  - execution restarts at pc=0.
